// File: rtl/speed_meter_mc.sv
// Multi-channel speed/occupancy datapath: per-channel ms timers, a shared round-robin
// restoring divider producing DIST_CONST / time_ms, and a capacity-limited occupancy counter with barrier hold.
module speed_meter_mc #(
  parameter int CHANNELS    = 2,
  parameter int WIDTH_MS    = 14,
  parameter int WIDTH_SPEED = 14,
  parameter int SYS_FREQ    = 50000000,
  parameter int DIST_CONST  = 14400,
  parameter int CAP_WIDTH   = 4,
  parameter int CAPACITY    = 10,
  parameter int HOLD_MS     = 2000
) (
  input  logic                                              clk,
  input  logic                                              reset,
  input  logic [CHANNELS-1:0]                               s_entry,
  input  logic [CHANNELS-1:0]                               s_exit,
  input  logic                                              veh_in,
  input  logic                                              veh_out,
  output logic [WIDTH_SPEED-1:0]                            speed,
  output logic [((CHANNELS > 1) ? $clog2(CHANNELS) : 1)-1:0] speed_ch,
  output logic                                              speed_valid,
  output logic [CHANNELS-1:0]                               timeout_err,
  output logic [CAP_WIDTH-1:0]                              num_veh,
  output logic                                              full,
  output logic                                              empty,
  output logic                                              reject,
  output logic                                              en_barrier
);

  localparam int CH_W   = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;
  localparam int PDIV   = SYS_FREQ / 1000;
  localparam int PW     = (PDIV > 1) ? $clog2(PDIV) : 1;
  localparam int HW     = $clog2(HOLD_MS + 1);
  localparam int IW     = $clog2(WIDTH_SPEED + 1);
  localparam logic [PW-1:0]          PRESC_MAX = PW'(PDIV - 1);
  localparam logic [HW-1:0]          HOLD_LD   = HW'(HOLD_MS);
  localparam logic [WIDTH_SPEED-1:0] DIST_LD   = WIDTH_SPEED'(DIST_CONST);
  localparam logic [CAP_WIDTH-1:0]   CAP_MAX   = CAP_WIDTH'(CAPACITY);

  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_TIMING = 2'd1;
  localparam logic [1:0] ST_PEND   = 2'd2;

  localparam logic [1:0] DV_IDLE = 2'd0;
  localparam logic [1:0] DV_RUN  = 2'd1;
  localparam logic [1:0] DV_DONE = 2'd2;

  logic [PW-1:0]          presc_r;
  logic                   tick_s;
  logic [1:0]             ch_state_r [CHANNELS];
  logic [WIDTH_MS-1:0]    ch_time_r  [CHANNELS];
  logic [CHANNELS-1:0]    timeout_r;
  logic [CH_W-1:0]        rr_ptr_r;
  logic                   grant_valid_s;
  logic [CH_W-1:0]        grant_idx_s;
  int                     best_s;
  int                     dist_s;
  logic [1:0]             div_state_r;
  logic [IW-1:0]          iter_r;
  logic [WIDTH_MS-1:0]    rem_r;
  logic [WIDTH_SPEED-1:0] quo_r;
  logic [WIDTH_MS-1:0]    dvs_r;
  logic [CH_W-1:0]        dch_r;
  logic [WIDTH_MS:0]      trial_s;
  logic                   ge_s;
  logic [WIDTH_MS-1:0]    rem_nxt_s;
  logic [WIDTH_SPEED-1:0] quo_nxt_s;
  logic [WIDTH_SPEED-1:0] speed_r;
  logic [CH_W-1:0]        speed_ch_r;
  logic                   speed_valid_r;
  logic [CAP_WIDTH-1:0]   num_r;
  logic                   full_s;
  logic                   empty_s;
  logic                   accept_s;
  logic                   reject_r;
  logic                   en_barrier_r;
  logic [HW-1:0]          hold_r;

  assign tick_s      = (presc_r == PRESC_MAX);
  assign full_s      = (num_r == CAP_MAX);
  assign empty_s     = (num_r == '0);
  // A simultaneous veh_out frees a slot, so the entry is honoured even at capacity.
  assign accept_s    = veh_in & (veh_out | ~full_s);

  assign speed       = speed_r;
  assign speed_ch    = speed_ch_r;
  assign speed_valid = speed_valid_r;
  assign timeout_err = timeout_r;
  assign num_veh     = num_r;
  assign full        = full_s;
  assign empty       = empty_s;
  assign reject      = reject_r;
  assign en_barrier  = en_barrier_r;

  // Free-running millisecond prescaler.
  always_ff @(posedge clk) begin
    if (reset) begin
      presc_r <= '0;
    end else begin
      presc_r <= tick_s ? '0 : presc_r + 1'b1;
    end
  end

  // Per-channel entry/exit timer FSMs.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int c = 0; c < CHANNELS; c++) begin
        ch_state_r[c] <= ST_IDLE;
        ch_time_r[c]  <= '0;
      end
      timeout_r <= '0;
    end else begin
      for (int c = 0; c < CHANNELS; c++) begin
        timeout_r[c] <= 1'b0;
        case (ch_state_r[c])
          ST_IDLE: begin
            if (s_entry[c]) begin
              ch_state_r[c] <= ST_TIMING;
              ch_time_r[c]  <= '0;
            end
          end
          ST_TIMING: begin
            if (s_entry[c]) begin
              ch_time_r[c] <= '0;
            end else if (s_exit[c]) begin
              ch_state_r[c] <= ST_PEND;
              if (ch_time_r[c] == '0) begin
                ch_time_r[c] <= WIDTH_MS'(1);
              end
            end else if (tick_s) begin
              if (ch_time_r[c] == '1) begin
                ch_state_r[c] <= ST_IDLE;
                timeout_r[c]  <= 1'b1;
              end else begin
                ch_time_r[c] <= ch_time_r[c] + 1'b1;
              end
            end
          end
          ST_PEND: begin
            if (grant_valid_s && (grant_idx_s == CH_W'(c))) begin
              ch_state_r[c] <= ST_IDLE;
            end
          end
          default: ch_state_r[c] <= ST_IDLE;
        endcase
      end
    end
  end

  // Round-robin pick: pending channel with the smallest cyclic distance from rr_ptr.
  always_comb begin
    grant_idx_s = '0;
    best_s      = CHANNELS;
    dist_s      = 0;
    for (int c = 0; c < CHANNELS; c++) begin
      dist_s = (c >= int'(rr_ptr_r)) ? (c - int'(rr_ptr_r)) : (c + CHANNELS - int'(rr_ptr_r));
      if ((ch_state_r[c] == ST_PEND) && (dist_s < best_s)) begin
        best_s      = dist_s;
        grant_idx_s = CH_W'(c);
      end else begin
        grant_idx_s = grant_idx_s;
      end
    end
    grant_valid_s = (best_s < CHANNELS) && (div_state_r == DV_IDLE);
  end

  // One restoring-division step; the remainder always stays below the divisor.
  always_comb begin
    trial_s   = {rem_r, quo_r[WIDTH_SPEED-1]};
    ge_s      = (trial_s >= {1'b0, dvs_r});
    if (ge_s) begin
      rem_nxt_s = trial_s[WIDTH_MS-1:0] - dvs_r;
    end else begin
      rem_nxt_s = trial_s[WIDTH_MS-1:0];
    end
    quo_nxt_s = {quo_r[WIDTH_SPEED-2:0], ge_s};
  end

  // Shared divider sequencer, arbiter pointer and result registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      div_state_r   <= DV_IDLE;
      iter_r        <= '0;
      rem_r         <= '0;
      quo_r         <= '0;
      dvs_r         <= '0;
      dch_r         <= '0;
      rr_ptr_r      <= '0;
      speed_r       <= '0;
      speed_ch_r    <= '0;
      speed_valid_r <= 1'b0;
    end else begin
      speed_valid_r <= 1'b0;
      case (div_state_r)
        DV_IDLE: begin
          if (grant_valid_s) begin
            rem_r       <= '0;
            quo_r       <= DIST_LD;
            dvs_r       <= ch_time_r[grant_idx_s];
            dch_r       <= grant_idx_s;
            iter_r      <= IW'(WIDTH_SPEED - 1);
            rr_ptr_r    <= (grant_idx_s == CH_W'(CHANNELS - 1)) ? '0 : grant_idx_s + 1'b1;
            div_state_r <= DV_RUN;
          end
        end
        DV_RUN: begin
          rem_r <= rem_nxt_s;
          quo_r <= quo_nxt_s;
          if (iter_r == '0) begin
            div_state_r   <= DV_DONE;
            speed_r       <= quo_nxt_s;
            speed_ch_r    <= dch_r;
            speed_valid_r <= 1'b1;
          end else begin
            iter_r <= iter_r - 1'b1;
          end
        end
        DV_DONE: div_state_r <= DV_IDLE;
        default: div_state_r <= DV_IDLE;
      endcase
    end
  end

  // Occupancy counter with reject on a refused entry.
  always_ff @(posedge clk) begin
    if (reset) begin
      num_r    <= '0;
      reject_r <= 1'b0;
    end else begin
      reject_r <= 1'b0;
      case ({veh_in, veh_out})
        2'b10: begin
          if (full_s) begin
            reject_r <= 1'b1;
          end else begin
            num_r <= num_r + 1'b1;
          end
        end
        2'b01: begin
          if (!empty_s) begin
            num_r <= num_r - 1'b1;
          end
        end
        default: num_r <= num_r;
      endcase
    end
  end

  // Barrier hold-open timer, reloaded by every accepted entry.
  always_ff @(posedge clk) begin
    if (reset) begin
      en_barrier_r <= 1'b0;
      hold_r       <= '0;
    end else begin
      if (accept_s) begin
        en_barrier_r <= 1'b1;
        hold_r       <= HOLD_LD;
      end else if (tick_s && en_barrier_r) begin
        if (hold_r <= HW'(1)) begin
          hold_r       <= '0;
          en_barrier_r <= 1'b0;
        end else begin
          hold_r <= hold_r - 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_speed_meter_mc.sv
// Directed, table-driven bench for speed_meter_mc with a 4-clock ms tick and a 3 ms barrier hold.
module tb_speed_meter_mc;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [1:0] s_entry = 2'b00;
  logic [1:0] s_exit = 2'b00;
  logic       veh_in = 1'b0;
  logic       veh_out = 1'b0;
  logic [13:0] speed;
  logic [0:0] speed_ch;
  logic       speed_valid;
  logic [1:0] timeout_err;
  logic [3:0] num_veh;
  logic       full;
  logic       empty;
  logic       reject;
  logic       en_barrier;

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  typedef struct {
    logic vin;
    logic vout;
    int   num;
    logic full;
    logic empty;
    logic rej;
  } occ_vec_t;

  occ_vec_t tbl [16];

  speed_meter_mc #(
    .CHANNELS(2), .WIDTH_MS(14), .WIDTH_SPEED(14), .SYS_FREQ(4000),
    .DIST_CONST(14400), .CAP_WIDTH(4), .CAPACITY(10), .HOLD_MS(3)
  ) dut (
    .clk(clk), .reset(reset), .s_entry(s_entry), .s_exit(s_exit),
    .veh_in(veh_in), .veh_out(veh_out), .speed(speed), .speed_ch(speed_ch),
    .speed_valid(speed_valid), .timeout_err(timeout_err), .num_veh(num_veh),
    .full(full), .empty(empty), .reject(reject), .en_barrier(en_barrier)
  );

  always #5 clk = ~clk;

  // Prescaler phase model: tick cycles are those with cyc % 4 == 3.
  always @(posedge clk) begin
    if (reset) cyc <= 0;
    else cyc <= cyc + 1;
  end

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_phase(input int p);
    while ((cyc % 4) != p) step();
  endtask

  task automatic wait_valid(input int start, output int lat);
    lat = start;
    while (!speed_valid && lat < 64) begin
      step();
      lat++;
    end
  endtask

  task automatic single(input logic [1:0] m, input int gap, input int exp_ch,
                        input int exp_spd, input string tag);
    int lat;
    wait_phase(0);
    s_entry = m; step(); s_entry = 2'b00;
    repeat (gap - 1) step();
    s_exit = m; step(); s_exit = 2'b00;
    wait_valid(1, lat);
    chk({tag, "_latency"}, lat, 16);
    chk({tag, "_speed"}, speed, exp_spd);
    chk({tag, "_ch"}, speed_ch, exp_ch);
    step();
    chk({tag, "_valid_pulse"}, speed_valid, 0);
  endtask

  // ch0 runs 400 clk (100 ms -> 144), ch1 runs 200 clk (50 ms -> 288); both exit together.
  task automatic pair(input int ch_a, input int spd_a, input int ch_b, input int spd_b,
                      input string tag);
    int lat;
    wait_phase(0);
    s_entry = 2'b01; step(); s_entry = 2'b00;
    repeat (199) step();
    s_entry = 2'b10; step(); s_entry = 2'b00;
    repeat (199) step();
    s_exit = 2'b11; step(); s_exit = 2'b00;
    wait_valid(1, lat);
    chk({tag, "_first_latency"}, lat, 16);
    chk({tag, "_first_ch"}, speed_ch, ch_a);
    chk({tag, "_first_speed"}, speed, spd_a);
    step();
    chk({tag, "_first_pulse"}, speed_valid, 0);
    wait_valid(1, lat);
    chk({tag, "_gap"}, lat, 16);
    chk({tag, "_second_ch"}, speed_ch, ch_b);
    chk({tag, "_second_speed"}, speed, spd_b);
  endtask

  initial begin
    int cnt;
    int sv_seen;

    tbl[0] = '{1'b0, 1'b1, 0, 1'b0, 1'b1, 1'b0};
    for (int i = 1; i <= 10; i++) tbl[i] = '{1'b1, 1'b0, i, (i == 10), 1'b0, 1'b0};
    tbl[11] = '{1'b1, 1'b0, 10, 1'b1, 1'b0, 1'b1};
    tbl[12] = '{1'b1, 1'b1, 10, 1'b1, 1'b0, 1'b0};
    tbl[13] = '{1'b0, 1'b1, 9, 1'b0, 1'b0, 1'b0};
    tbl[14] = '{1'b1, 1'b1, 9, 1'b0, 1'b0, 1'b0};
    tbl[15] = '{1'b0, 1'b0, 9, 1'b0, 1'b0, 1'b0};

    repeat (3) step();
    reset = 1'b0;
    chk("rst_speed", speed, 0);
    chk("rst_speed_ch", speed_ch, 0);
    chk("rst_valid", speed_valid, 0);
    chk("rst_timeout", timeout_err, 0);
    chk("rst_num", num_veh, 0);
    chk("rst_full", full, 0);
    chk("rst_empty", empty, 1);
    chk("rst_reject", reject, 0);
    chk("rst_barrier", en_barrier, 0);

    single(2'b01, 400, 0, 144, "ch0_400clk");
    single(2'b10, 1, 1, 14400, "ch1_no_tick");
    pair(0, 144, 1, 288, "pair_rr0");
    single(2'b01, 1, 0, 14400, "ch0_rr_adv");
    pair(1, 288, 0, 144, "pair_rr1");

    // Timer saturation: 16384th tick after entry, no divide issued.
    wait_phase(0);
    s_entry = 2'b01; step(); s_entry = 2'b00;
    cnt = 1;
    sv_seen = 0;
    while (!timeout_err[0] && cnt < 70000) begin
      if (speed_valid) sv_seen++;
      step();
      cnt++;
    end
    chk("timeout_cycles", cnt, 65536);
    chk("timeout_other_ch", timeout_err[1], 0);
    step();
    chk("timeout_pulse", timeout_err, 0);
    repeat (20) begin
      if (speed_valid) sv_seen++;
      step();
    end
    chk("timeout_no_valid", sv_seen, 0);

    // Barrier hold with a restart after two ticks; offsets relative to entry cycle V.
    wait_phase(0);
    veh_in = 1'b1; step(); veh_in = 1'b0;
    chk("bar_open", en_barrier, 1);
    chk("bar_num", num_veh, 1);
    repeat (7) step();
    chk("bar_before_reload", en_barrier, 1);
    veh_in = 1'b1; step(); veh_in = 1'b0;
    repeat (3) step();
    chk("bar_held_at_v12", en_barrier, 1);
    repeat (7) step();
    chk("bar_held_at_v19", en_barrier, 1);
    step();
    chk("bar_closed_at_v20", en_barrier, 0);

    reset = 1'b1; step(); reset = 1'b0;
    for (int i = 0; i < 16; i++) begin
      veh_in  = tbl[i].vin;
      veh_out = tbl[i].vout;
      step();
      chk($sformatf("occ%0d_num", i), num_veh, tbl[i].num);
      chk($sformatf("occ%0d_full", i), full, tbl[i].full);
      chk($sformatf("occ%0d_empty", i), empty, tbl[i].empty);
      chk($sformatf("occ%0d_reject", i), reject, tbl[i].rej);
    end
    veh_in  = 1'b0;
    veh_out = 1'b0;

    // Reset during a divide on ch0 while ch1 is still timing.
    wait_phase(0);
    s_entry = 2'b11; step(); s_entry = 2'b00;
    repeat (10) step();
    s_exit = 2'b01; step(); s_exit = 2'b00;
    repeat (5) step();
    reset = 1'b1; step(); reset = 1'b0;
    chk("mid_rst_speed", speed, 0);
    chk("mid_rst_speed_ch", speed_ch, 0);
    chk("mid_rst_valid", speed_valid, 0);
    chk("mid_rst_timeout", timeout_err, 0);
    chk("mid_rst_num", num_veh, 0);
    chk("mid_rst_empty", empty, 1);
    chk("mid_rst_full", full, 0);
    chk("mid_rst_reject", reject, 0);
    chk("mid_rst_barrier", en_barrier, 0);
    sv_seen = 0;
    s_exit = 2'b10; step(); s_exit = 2'b00;
    repeat (40) begin
      if (speed_valid) sv_seen++;
      step();
    end
    chk("mid_rst_no_stale_valid", sv_seen, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
